pipe_stage_bank: RTL and testbench

- Parametrised successor to the fixed dual-lane pipeline buffer: a chain of STAGES register stages, each LANES wide, carrying DATA_W-bit payloads with per-lane valid bits.
- Adds a global stall, in-order per-lane issue hold with bubble insertion, a per-stage flush, an upstream ready signal, and zeroing of the payload on every bubble.
- Sits between decode/issue and writeback. It replaces hand-written per-stage always blocks in the core pipeline.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_bank_if.sv | 28 ++
 rtl/pipe_stage_reg.sv | 67 ++++++
 rtl/pipe_stage_bank.sv | 131 +++++++++++++
 tb/tb_pipe_stage_bank.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_bank pipeline buffer: per-lane
// register actions and the index helpers used to address the flattened
// stage_valid / stage_data vectors.
package pipe_pkg;

  // What a single lane register does on the next clock edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } stage_act_e;

  // Bit position of stage s, lane l inside a flattened valid vector.
  function automatic int vld_idx(input int s, input int l, input int lanes);
    return (s * lanes) + l;
  endfunction

  // Low bit of stage s, lane l payload inside a flattened data vector.
  function automatic int dat_off(input int s, input int l, input int lanes, input int data_w);
    return vld_idx(s, l, lanes) * data_w;
  endfunction

endpackage

// File: rtl/pipe_stage_bank_if.sv
// Bus bundle for pipe_stage_bank: upstream issue handshake, pipeline
// controls and the flattened per-stage view handed to consumers.
interface pipe_stage_bank_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int STAGES = 4
);
  logic                             stall_i;
  logic [LANES-1:0]                 valid_i;
  logic [LANES*DATA_W-1:0]          data_i;
  logic                             ready_o;
  logic [LANES-1:0]                 lane_hold_i;
  logic [STAGES-1:0]                flush_i;
  logic [STAGES*LANES-1:0]          stage_valid_o;
  logic [STAGES*LANES*DATA_W-1:0]   stage_data_o;

  // Issue/control side
  modport master (
    output stall_i, valid_i, data_i, lane_hold_i, flush_i,
    input  ready_o, stage_valid_o, stage_data_o
  );

  // Pipeline side
  modport slave (
    input  stall_i, valid_i, data_i, lane_hold_i, flush_i,
    output ready_o, stage_valid_o, stage_data_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: LANES valid/payload registers. Each lane is told
// to hold, load its upstream entry, or become a bubble. Any entry that
// ends up invalid always carries an all-zero payload.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 64
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  stage_act_e              act_i [LANES],
  input  logic [LANES-1:0]        up_valid_i,
  input  logic [LANES*DATA_W-1:0] up_data_i,
  output logic [LANES-1:0]        valid_o,
  output logic [LANES*DATA_W-1:0] data_o
);

  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES*DATA_W-1:0] data_q,  data_d;

  // Select each lane's next entry from its action, zeroing bubbles
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int l = 0; l < LANES; l++) begin
      case (act_i[l])
        ACT_HOLD: begin
          valid_d[l]                                   = valid_q[l];
          data_d[dat_off(0, l, LANES, DATA_W) +: DATA_W] = data_q[dat_off(0, l, LANES, DATA_W) +: DATA_W];
        end
        ACT_LOAD: begin
          valid_d[l] = up_valid_i[l];
          if (up_valid_i[l]) begin
            data_d[dat_off(0, l, LANES, DATA_W) +: DATA_W] = up_data_i[dat_off(0, l, LANES, DATA_W) +: DATA_W];
          end else begin
            data_d[dat_off(0, l, LANES, DATA_W) +: DATA_W] = '0;
          end
        end
        ACT_BUBBLE: begin
          valid_d[l]                                   = 1'b0;
          data_d[dat_off(0, l, LANES, DATA_W) +: DATA_W] = '0;
        end
        default: begin
          // Unknown action: kill the entry rather than pass garbage on
          valid_d[l]                                   = 1'b0;
          data_d[dat_off(0, l, LANES, DATA_W) +: DATA_W] = '0;
        end
      endcase
    end
  end

  // Lane registers with asynchronous clear
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_bank.sv
// pipe_stage_bank: STAGES x LANES register pipeline between issue and
// writeback with global stall, per-stage flush and in-order issue hold.
// Per edge the priority is reset, flush, stall, hold, normal advance.
// Optional macro PIPE_STAGE_BANK_PERF_EN adds bubble_cnt_o, a saturating
// count of invalid lanes leaving the last stage on unstalled edges.
module pipe_stage_bank
  import pipe_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int STAGES = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
`ifdef PIPE_STAGE_BANK_PERF_EN
  output logic [31:0]        bubble_cnt_o,
`endif
  pipe_stage_bank_if.slave   bus
);

  logic                           flush_any_s;
  int                             flush_top_s;
  logic                           hold_any_s;
  int                             hold_lane_s;
  stage_act_e                     act_s [STAGES][LANES];
  logic [STAGES*LANES-1:0]        stage_valid_s;
  logic [STAGES*LANES*DATA_W-1:0] stage_data_s;

  // Upstream may only issue when nothing stalls or holds stage 0
  assign bus.ready_o = ~bus.stall_i & ~(|bus.lane_hold_i);

  // Highest flushed stage and lowest (oldest) held lane
  always_comb begin
    flush_any_s = |bus.flush_i;
    flush_top_s = 0;
    for (int s = 0; s < STAGES; s++) begin
      flush_top_s = bus.flush_i[s] ? s : flush_top_s;
    end
    hold_any_s  = |bus.lane_hold_i;
    hold_lane_s = LANES;
    for (int l = LANES - 1; l >= 0; l--) begin
      hold_lane_s = bus.lane_hold_i[l] ? l : hold_lane_s;
    end
  end

  // Per stage/lane action in priority order: flush, stall, hold, advance
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      for (int l = 0; l < LANES; l++) begin
        act_s[s][l] = ACT_LOAD;
        if (flush_any_s && (s <= flush_top_s)) begin
          act_s[s][l] = ACT_BUBBLE;
        end else if (flush_any_s && !bus.stall_i && (s == flush_top_s + 1)) begin
          // Upstream of this stage was just killed
          act_s[s][l] = ACT_BUBBLE;
        end else if (bus.stall_i) begin
          act_s[s][l] = ACT_HOLD;
        end else if (hold_any_s && (s == 0)) begin
          // Held lanes stay; older lanes move on and leave a bubble behind
          act_s[s][l] = (l >= hold_lane_s) ? ACT_HOLD : ACT_BUBBLE;
        end else if (hold_any_s && (s == 1)) begin
          act_s[s][l] = (l >= hold_lane_s) ? ACT_BUBBLE : ACT_LOAD;
        end else begin
          act_s[s][l] = ACT_LOAD;
        end
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [LANES-1:0]        up_valid_s;
    logic [LANES*DATA_W-1:0] up_data_s;

    if (s == 0) begin : g_head
      assign up_valid_s = bus.valid_i;
      assign up_data_s  = bus.data_i;
    end else begin : g_body
      assign up_valid_s = stage_valid_s[vld_idx(s - 1, 0, LANES) +: LANES];
      assign up_data_s  = stage_data_s[dat_off(s - 1, 0, LANES, DATA_W) +: LANES*DATA_W];
    end

    pipe_stage_reg #(
      .LANES  (LANES),
      .DATA_W (DATA_W)
    ) u_reg (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .act_i      (act_s[s]),
      .up_valid_i (up_valid_s),
      .up_data_i  (up_data_s),
      .valid_o    (stage_valid_s[vld_idx(s, 0, LANES) +: LANES]),
      .data_o     (stage_data_s[dat_off(s, 0, LANES, DATA_W) +: LANES*DATA_W])
    );
  end

  assign bus.stage_valid_o = stage_valid_s;
  assign bus.stage_data_o  = stage_data_s;

`ifdef PIPE_STAGE_BANK_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, idle_lanes_s;
  logic [32:0] bubble_sum_s;

  // Add the invalid lanes in the last stage on every unstalled edge, saturating
  always_comb begin
    idle_lanes_s = 32'd0;
    for (int l = 0; l < LANES; l++) begin
      idle_lanes_s = idle_lanes_s + {31'd0, ~stage_valid_s[vld_idx(STAGES - 1, l, LANES)]};
    end
    bubble_sum_s = {1'b0, bubble_cnt_q} + {1'b0, idle_lanes_s};
    if (bus.stall_i) begin
      bubble_cnt_d = bubble_cnt_q;
    end else if (bubble_sum_s[32]) begin
      bubble_cnt_d = 32'hFFFF_FFFF;
    end else begin
      bubble_cnt_d = bubble_sum_s[31:0];
    end
  end

  // Bubble counter register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bubble_cnt_q <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Scoreboard bench for pipe_stage_bank: the driver updates a lane/stage
// array model on each issued cycle and queues the expected pipeline
// contents; a monitor compares them just after the following edge.
module tb_pipe_stage_bank;
  localparam int LANES  = 2;
  localparam int DATA_W = 64;
  localparam int STAGES = 4;
  localparam int VW     = STAGES * LANES;
  localparam int DW     = VW * DATA_W;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  pipe_stage_bank_if #(.LANES(LANES), .DATA_W(DATA_W), .STAGES(STAGES)) bus ();

`ifdef PIPE_STAGE_BANK_PERF_EN
  logic [31:0] bubble_cnt_o;
`endif

  pipe_stage_bank #(.LANES(LANES), .DATA_W(DATA_W), .STAGES(STAGES)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
`ifdef PIPE_STAGE_BANK_PERF_EN
    .bubble_cnt_o (bubble_cnt_o),
`endif
    .bus          (bus)
  );

  typedef struct packed {
    logic [VW-1:0] v;
    logic [DW-1:0] d;
    logic          rdy;
    logic [31:0]   cnt;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: what each stage/lane holds, plus the bubble tally
  logic              mv [STAGES][LANES];
  logic [DATA_W-1:0] md [STAGES][LANES];
  logic [31:0]       mcnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < STAGES; s++)
      for (int l = 0; l < LANES; l++) begin
        mv[s][l] = 1'b0;
        md[s][l] = '0;
      end
    mcnt = 32'd0;
  endfunction

  // One clock edge of the pipeline, written from the behavioural rules
  function automatic void model_step(input logic [LANES-1:0] vi, input logic [LANES*DATA_W-1:0] di,
                                     input logic st, input logic [LANES-1:0] hd,
                                     input logic [STAGES-1:0] fl);
    logic              nv [STAGES][LANES];
    logic [DATA_W-1:0] nd [STAGES][LANES];
    int ftop = -1;
    int hl   = -1;
    for (int s = 0; s < STAGES; s++) if (fl[s]) ftop = s;
    for (int l = LANES - 1; l >= 0; l--) if (hd[l]) hl = l;
    if (!st)
      for (int l = 0; l < LANES; l++)
        if (!mv[STAGES-1][l] && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
    nv = mv;
    nd = md;
    if (!st) begin
      for (int s = STAGES - 1; s >= 1; s--)
        for (int l = 0; l < LANES; l++) begin
          nv[s][l] = mv[s-1][l];
          nd[s][l] = md[s-1][l];
        end
      for (int l = 0; l < LANES; l++) begin
        if (hl < 0) begin
          nv[0][l] = vi[l];
          nd[0][l] = vi[l] ? di[l*DATA_W +: DATA_W] : '0;
        end else if (l >= hl) begin
          nv[0][l] = mv[0][l];
          nd[0][l] = md[0][l];
          if (STAGES > 1) begin
            nv[1][l] = 1'b0;
            nd[1][l] = '0;
          end
        end else begin
          nv[0][l] = 1'b0;
          nd[0][l] = '0;
        end
      end
    end
    if (ftop >= 0)
      for (int s = 0; s < STAGES; s++)
        if (s <= ftop || (!st && s == ftop + 1))
          for (int l = 0; l < LANES; l++) begin
            nv[s][l] = 1'b0;
            nd[s][l] = '0;
          end
    mv = nv;
    md = nd;
  endfunction

  function automatic exp_t model_snapshot(input logic rdy);
    exp_t e;
    e.rdy = rdy;
    e.cnt = mcnt;
    for (int s = 0; s < STAGES; s++)
      for (int l = 0; l < LANES; l++) begin
        e.v[s*LANES + l]                   = mv[s][l];
        e.d[(s*LANES + l)*DATA_W +: DATA_W] = md[s][l];
      end
    return e;
  endfunction

  // Called just before an edge: apply inputs, predict, then move on a cycle
  task automatic drive(input logic [LANES-1:0] vi, input logic [LANES*DATA_W-1:0] di,
                       input logic st, input logic [LANES-1:0] hd, input logic [STAGES-1:0] fl);
    bus.valid_i     = vi;
    bus.data_i      = di;
    bus.stall_i     = st;
    bus.lane_hold_i = hd;
    bus.flush_i     = fl;
    model_step(vi, di, st, hd, fl);
    sb_q.push_back(model_snapshot(!st && !(|hd)));
    @(negedge clock_i);
  endtask

  function automatic logic [LANES*DATA_W-1:0] rand_data();
    logic [LANES*DATA_W-1:0] d;
    for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = {$urandom(), $urandom()};
    return d;
  endfunction

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) drive(2'b11, rand_data(), 1'b0, 2'b00, 4'b0000);
  endtask

  // Monitor: compare the queued prediction just after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stage_valid", DW'(bus.stage_valid_o), DW'(e.v));
        chk("stage_data", bus.stage_data_o, e.d);
        chk("ready", DW'(bus.ready_o), DW'(e.rdy));
`ifdef PIPE_STAGE_BANK_PERF_EN
        chk("bubble_cnt_model", DW'(bubble_cnt_o), DW'(e.cnt));
`endif
      end
    end
  end

  initial begin
    logic [31:0]             r;
    logic [LANES*DATA_W-1:0] d;
    logic [DATA_W-1:0]       a5;
    logic                    st;
    logic [LANES-1:0]        hd;
    logic [STAGES-1:0]       fl;

    bus.valid_i = '0; bus.data_i = '0; bus.stall_i = 1'b0;
    bus.lane_hold_i = '0; bus.flush_i = '0;
    model_reset();

    // Power-on reset
    @(negedge clock_i);
    #1;
    chk("reset_valid", DW'(bus.stage_valid_o), '0);
    chk("reset_data", bus.stage_data_o, '0);
    @(negedge clock_i);
    reset_i = 1'b0;
    chk("ready_after_reset", DW'(bus.ready_o), DW'(1'b1));

    // Lane 0 only for 14 unstalled edges: 4*2 + 10*1 bubbles leave stage 3
    for (int i = 0; i < 14; i++) begin
      d = '0;
      d[DATA_W-1:0] = DATA_W'(i + 100);
      drive(2'b01, d, 1'b0, 2'b00, 4'b0000);
    end
`ifdef PIPE_STAGE_BANK_PERF_EN
    chk("bubble_cnt_18", DW'(bubble_cnt_o), DW'(32'd18));
`endif

    // Back-to-back streaming of incrementing pairs
    for (int i = 0; i < 10; i++) begin
      d = '0;
      d[DATA_W-1:0]        = DATA_W'(i + 1);
      d[2*DATA_W-1:DATA_W] = DATA_W'(i + 2);
      drive(2'b11, d, 1'b0, 2'b00, 4'b0000);
    end

    // Lane-1 hold with stage 0 occupied, then normal again
    drive(2'b11, rand_data(), 1'b0, 2'b00, 4'b0000);
    drive(2'b11, rand_data(), 1'b0, 2'b10, 4'b0000);
    drive(2'b11, rand_data(), 1'b0, 2'b00, 4'b0000);
    drive(2'b11, rand_data(), 1'b0, 2'b01, 4'b0000);

    // Stall beats hold
    fill(4);
    drive(2'b11, rand_data(), 1'b1, 2'b01, 4'b0000);

    // Flush of stage 1, unstalled and stalled
    fill(4);
    drive(2'b11, rand_data(), 1'b0, 2'b00, 4'b0010);
    fill(4);
    drive(2'b11, rand_data(), 1'b1, 2'b00, 4'b0010);
    drive(2'b11, rand_data(), 1'b0, 2'b10, 4'b0001);
    drive(2'b11, rand_data(), 1'b0, 2'b00, 4'b1000);

    // Asynchronous reset between edges with a full pipeline
    a5 = {32'hA5A5_A5A5, 32'hA5A5_A5A5};
    for (int i = 0; i < 4; i++) drive(2'b11, {a5, a5}, 1'b0, 2'b00, 4'b0000);
    bus.valid_i = '0; bus.data_i = '0;
    #2 reset_i = 1'b1;
    #1;
    chk("async_reset_valid", DW'(bus.stage_valid_o), '0);
    chk("async_reset_data", bus.stage_data_o, '0);
    #1 reset_i = 1'b0;
    model_reset();
    chk("ready_after_async_reset", DW'(bus.ready_o), DW'(1'b1));
    drive(2'b00, '0, 1'b0, 2'b00, 4'b0000);

    // Randomised mix of traffic, stalls, holds and flushes
    for (int i = 0; i < 400; i++) begin
      r  = $urandom();
      st = ($urandom_range(0, 3) == 32'd0);
      hd = ($urandom_range(0, 4) == 32'd0) ? r[LANES+1:2] : 2'b00;
      fl = ($urandom_range(0, 9) == 32'd0) ? r[STAGES+3:4] : 4'b0000;
      drive(r[LANES-1:0], rand_data(), st, hd, fl);
    end

    // Let the monitor finish, with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clock_i);
    #2;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
